// File: rtl/cpu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// register-file move code and the sequencer state enum.
package cpu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    localparam logic [1:0] MOVE_HILO = 2'b11;
    localparam logic [1:0] MOVE_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIX   = 2'b10,
        ST_WRITE = 2'b11
    } mdu_state_e;

    // op[1] selects divide, op[0] selects the signed variant
    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_v);
        return op_v[0];
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration over the {hi, lo} working register:
// shift-add for multiply, compare-subtract-shift (restoring) for divide.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] diff_s;

    // Remainder before the shift is below the divisor, so the difference fits WIDTH bits
    always_comb begin
        sum_s  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_s  = {hi_i, lo_i[WIDTH-1]};
        diff_s = rem_s[WIDTH-1:0] - opnd_i;
        if (is_div_i) begin
            if (rem_s >= {1'b0, opnd_i}) begin
                hi_o = diff_s;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_s[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = sum_s[WIDTH:1];
            lo_o = {sum_s[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Iterative mult/div sequencer owning HI/LO; commits {HI, LO} with move=2'b11.
// Optional MDU_EARLY_OUT_EN: multiply finishes early once the remaining multiplier bits are zero.
module hilo_mdu_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hiloRead,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             regWrite,
    output logic [1:0]       move,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    mdu_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_out_q, hi_out_d, lo_out_q, lo_out_d;
    logic             busy_q, busy_d, done_q, done_d, wr_q, wr_d;
    logic [1:0]       move_q, move_d;

    logic [WIDTH-1:0]   a_mag_s, b_mag_s, step_hi_s, step_lo_s, fix_hi_s, fix_lo_s;
    logic [2*WIDTH-1:0] prod_s;
`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] eo_mask_s;
    logic [CNT_W-1:0] eo_sh_s;
`endif

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_is_div(op_q)),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi_s),
        .lo_o     (step_lo_s)
    );

    // Operand magnitudes and the sign correction applied in FIX
    always_comb begin
        a_mag_s  = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
        b_mag_s  = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
        prod_s   = {acc_hi_q, acc_lo_q};
        if (op_is_div(op_q)) begin
            fix_lo_s = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
            fix_hi_s = neg_a_q ? -acc_hi_q : acc_hi_q;
        end else begin
            if (neg_a_q ^ neg_b_q) begin
                prod_s = -prod_s;
            end else begin
                prod_s = {acc_hi_q, acc_lo_q};
            end
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
`ifdef MDU_EARLY_OUT_EN
        eo_mask_s = {WIDTH{1'b1}} >> cnt_q;
        eo_sh_s   = CNT_W'(WIDTH) - cnt_q;
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        hi_out_d = hi_out_q;
        lo_out_d = lo_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    neg_a_d  = op_is_signed(op) & a[WIDTH-1];
                    neg_b_d  = op_is_signed(op) & b[WIDTH-1];
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    if (op_is_div(op) && (b == '0)) begin
                        acc_lo_d = '0;
                        opnd_d   = '0;
                        hi_out_d = a;
                        lo_out_d = {WIDTH{1'b1}};
                        state_d  = ST_WRITE;
                    end else begin
                        acc_lo_d = op_is_div(op) ? a_mag_s : b_mag_s;
                        opnd_d   = op_is_div(op) ? b_mag_s : a_mag_s;
                        state_d  = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
`ifdef MDU_EARLY_OUT_EN
                end else if (!op_is_div(op_q) && ((acc_lo_q & eo_mask_s) == '0)) begin
                    {acc_hi_d, acc_lo_d} = {acc_hi_q, acc_lo_q} >> eo_sh_s;
                    state_d = ST_FIX;
`endif
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_out_d = fix_hi_s;
                    lo_out_d = fix_lo_s;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered with it
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_WRITE);
        wr_d   = (state_d == ST_WRITE);
        move_d = (state_d == ST_WRITE) ? MOVE_HILO : MOVE_NONE;
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_q     <= 1'b0;
            move_q   <= MOVE_NONE;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            hi_out_q <= hi_out_d;
            lo_out_q <= lo_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            move_q   <= move_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign regWrite = wr_q;
    assign move     = move_q;
    assign hiOut    = hi_out_q;
    assign loOut    = lo_out_q;
    assign stall    = busy_q & hiloRead;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Randomized self-checking bench for hilo_mdu_ctrl against a plain-arithmetic HI/LO model.
module tb_hilo_mdu_ctrl;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        hiloRead;
    logic        busy, done, stall, regWrite;
    logic [1:0]  move;
    logic [31:0] hiOut, loOut;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

    hilo_mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hiloRead(hiloRead), .busy(busy), .done(done),
        .stall(stall), .regWrite(regWrite), .move(move), .hiOut(hiOut), .loOut(loOut)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, truncating signed division
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: p = {32'h0, x} * {32'h0, y};
            2'b01: p = sx * sy;
            default: begin
                if (y == 32'h0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    p = {x % y, x / y};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit flush_with_start, input bit poke_start);
        logic [31:0] eh, el;
        int lat_exp, cyc, bad_busy, bad_stall;
        model(o, x, y, eh, el);
        lat_exp = (o[1] && y == 32'h0) ? 1 : 34;
        @(negedge CLK);
        start = 1'b1; op = o; a = x; b = y; flush = flush_with_start; hiloRead = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        cyc = 1; bad_busy = 0; bad_stall = 0;
        while (!done && cyc < 100) begin
            if (busy !== 1'b1 || regWrite !== 1'b0) bad_busy++;
            hiloRead = 1'($urandom_range(0, 1));
            start = (poke_start && cyc == 5);
            if (start) begin
                op = 2'($urandom); a = $urandom; b = $urandom;
            end
            #1;
            if (stall !== hiloRead) bad_stall++;
            @(negedge CLK);
            start = 1'b0;
            cyc++;
        end
        hiloRead = 1'b1;
        #1;
        check_eq("latency", 64'(cyc), 64'(lat_exp));
        check_eq("hi", {32'h0, hiOut}, {32'h0, eh});
        check_eq("lo", {32'h0, loOut}, {32'h0, el});
        check_eq("write_strobe", {62'h0, regWrite, busy}, {62'h0, 1'b1, 1'b1});
        check_eq("move_write", {62'h0, move}, 64'd3);
        check_eq("stall_in_write", {63'h0, stall}, 64'd1);
        check_eq("busy_during_op", 64'(bad_busy), 64'd0);
        check_eq("stall_during_op", 64'(bad_stall), 64'd0);
        @(negedge CLK);
        #1;
        check_eq("after_write", {59'h0, done, regWrite, busy, stall, move[0]}, 64'd0);
        check_eq("hold_hilo", {hiOut, loOut}, {eh, el});
        hiloRead = 1'b0;
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic run_flush(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int at);
        int cyc, bad;
        @(negedge CLK);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge CLK);
        start = 1'b0; cyc = 1;
        while (cyc < at) begin
            @(negedge CLK);
            cyc++;
        end
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check_eq("flush_idle", {62'h0, busy, regWrite}, 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (regWrite !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_eq("flush_no_commit", 64'(bad), 64'd0);
        check_eq("flush_keeps_hilo", {hiOut, loOut}, {last_hi, last_lo});
    endtask

    task automatic run_reset(input int at);
        int bad;
        @(negedge CLK);
        start = 1'b1; op = 2'b00; a = $urandom; b = $urandom | 32'h1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 1; i < at; i++) @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check_eq("reset_ctrl", {59'h0, busy, done, regWrite, move}, 64'd0);
        check_eq("reset_hilo", {hiOut, loOut}, 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (regWrite !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_eq("reset_abandons", 64'(bad), 64'd0);
        last_hi = 32'h0;
        last_lo = 32'h0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        RSTn = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        flush = 1'b0; hiloRead = 1'b1;
        #12;
        check_eq("reset_state", {58'h0, busy, done, stall, regWrite, move}, 64'd0);
        check_eq("reset_outputs", {hiOut, loOut}, 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        hiloRead = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 1'b0, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        run_flush(2'b10, 32'h0000_0100, 32'h0000_0007, 10);
        run_flush(2'b01, 32'hFFFF_0000, 32'h0000_0123, 33);
        run_reset(20);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Iterative multiply/divide sequencer that owns the HI/LO pair of the register file.
- Accepts a mult/div command from EX and runs a 1-bit-per-cycle shift-add or restoring-divide loop.
- Drives the register-file write port with move=2'b11 to commit {HI, LO}.
- Stalls the pipeline when a HI/LO read arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
CLK  in  1  clock; all state updates on posedge
RSTn  in  1  asynchronous active-low reset
start  in  1  command valid from EX; sampled only in IDLE
op  in  2  00 multu, 01 mult, 10 divu, 11 div
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  squash the in-flight op; no commit
hiloRead  in  1  decode is reading HI or LO this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in WRITE
stall  out  1  busy & hiloRead (combinational)
regWrite  out  1  write strobe to register file; high only in WRITE
move  out  2  2'b11 in WRITE, else 2'b00
hiOut  out  WIDTH  HI result; drives register-file WData
loOut  out  WIDTH  LO result; drives register-file Wlo

Behaviour:
- Reset (RSTn=0, async): state=IDLE.
- Reset also clears: busy=0, done=0, regWrite=0, move=00, hiOut=0, loOut=0, counter=0, all datapath registers=0.
- Reset mid-operation abandons the op; no write is issued.
- FSM states: IDLE, CALC, FIX, WRITE.
- IDLE: on start=1, latch op, sign flags, |a|, |b| (magnitudes only for signed ops), counter=0.
  - Divide with b==0: go directly to WRITE with hi=a, lo=32'hFFFFFFFF.
  - Otherwise: go to CALC.
- IDLE with start=0: stay in IDLE.
- CALC, multiply: if acc_lo[0], acc_hi += multiplicand; then shift {carry, acc_hi, acc_lo} right by 1.
- CALC, divide (restoring): shift {rem, quo} left by 1; if rem >= divisor, subtract and set quo[0]=1.
- CALC ends after WIDTH iterations (counter==WIDTH-1), then goes to FIX.
- FIX, signed mult: negate the 64-bit product if sign(a)!=sign(b).
- FIX, signed div: quotient negated if signs differ; remainder takes the dividend's sign.
- Signed div 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. No trap.
- FIX loads hiOut/loOut and goes to WRITE.
- WRITE: regWrite=1, move=11, done=1 for exactly one cycle, then IDLE.
- Latency, start to done: WIDTH+2 cycles (34) normally; 1 cycle for divide-by-zero.
- start while busy: ignored. No queue. The pipeline guarantees no issue while busy.
- flush in CALC or FIX: return to IDLE next cycle; regWrite stays 0; hiOut/loOut keep prior values.
- flush in WRITE: ignored; the commit proceeds.
- flush and start together in IDLE: start wins.
- stall: combinational, not registered. Deasserts in the cycle after WRITE.
- The register file's write has #1 post-edge settling, so hiOut/loOut must be stable for the whole WRITE cycle.

Optional Feature:
Macro MDU_EARLY_OUT_EN.
- Defined: in CALC multiply, if the remaining unshifted multiplier bits are all zero, skip the remaining iterations.
  - Product is aligned with a single barrel shift by (WIDTH-counter), then the FSM goes to FIX.
  - Minimum multiply latency is 3 cycles.
  - Divide timing is unchanged.
- Undefined: fixed WIDTH iterations for all ops, with no shifter logic.

Decomposition:
- Shared package (cpu_pkg): op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV, MOVE_HILO=2'b11, state enum.
- One sub-module, mdu_iter_step: combinational single iteration (add-shift or compare-subtract-shift) over the {hi, lo} working register.
- The FSM and counter stay in the top.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; regWrite & move=11 for one cycle.
- mult a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=5, b=0 -> done one cycle after start; hi=5, lo=0xFFFFFFFF.
- Start divu, assert flush at cycle 10 -> IDLE next cycle, no regWrite.
- Restart, hold hiloRead during busy -> stall high throughout; low after WRITE.
- Assert RSTn=0 at cycle 20 -> all outputs cleared immediately.
